// File: rtl/hamming_decoder_pipe.sv
// Hamming(21,16) single-error-correcting decoder with a 2-stage valid/ready pipeline.
// Stage 1 registers the codeword and its syndrome; stage 2 applies the correction,
// extracts the 16 message bits and registers the result with its status flags.
// Optional build macro: HAMMING_ERR_CNT_EN adds saturating corrected/uncorrectable
// word counters of width CNT_W together with a synchronous clear input.
module hamming_decoder_pipe #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [20:0]      in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic [4:0]       out_syndrome,
    output logic             out_corrected,
    output logic             out_uncorrectable
`ifdef HAMMING_ERR_CNT_EN
    ,
    input  logic             cnt_clear,
    output logic [CNT_W-1:0] cnt_corrected,
    output logic [CNT_W-1:0] cnt_uncorr
`endif
);

    // Message bit j lives at Hamming position DATA_POS[j] (in_code index DATA_POS[j]-1).
    localparam int DATA_POS [16] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15, 17, 18, 19, 20, 21};

    // Positions that contribute to syndrome bit k: every position whose index has bit k set.
    function automatic logic [20:0] syn_mask(input int k);
        logic [20:0] m;
        m = '0;
        for (int p = 1; p <= 21; p++) begin
            m[p-1] = ((p >> k) & 1) == 1;
        end
        return m;
    endfunction

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    logic        s1_valid_q, s1_valid_d;
    logic [20:0] s1_code_q, s1_code_d;
    logic [4:0]  s1_syn_q, s1_syn_d;
    logic [4:0]  syn_comb;

    logic        out_valid_q, out_valid_d;
    logic [15:0] out_data_q, out_data_d;
    logic [4:0]  out_syn_q, out_syn_d;
    logic        out_corr_q, out_corr_d;
    logic        out_unc_q, out_unc_d;

    logic        s2_load;
    logic        in_accept;
    logic        out_fire;
    logic        corr_en;
    logic [20:0] fixed_code;
    logic [15:0] fixed_data;

    genvar gi;

    // Syndrome bit k is the parity of the positions selected by its mask.
    for (gi = 0; gi < 5; gi++) begin : g_syn
        localparam logic [20:0] MASK = syn_mask(gi);
        assign syn_comb[gi] = ^(in_code & MASK);
    end

    // Pull the message bits out of the (possibly corrected) codeword.
    for (gi = 0; gi < 16; gi++) begin : g_extract
        assign fixed_data[gi] = fixed_code[DATA_POS[gi]-1];
    end

    assign out_fire  = out_valid_q && out_ready;
    assign s2_load   = s1_valid_q && (!out_valid_q || out_ready);
    assign in_ready  = !s1_valid_q || s2_load;
    assign in_accept = in_valid && in_ready;

    // Syndromes 1..21 name the flipped position; 22..31 cannot come from a single error.
    assign corr_en    = (s1_syn_q != 5'd0) && (s1_syn_q <= 5'd21);
    assign fixed_code = corr_en ? (s1_code_q ^ (21'd1 << (s1_syn_q - 5'd1))) : s1_code_q;

    // Next-state for both pipeline stages; each stage holds unless it is loaded or drained.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_code_d   = s1_code_q;
        s1_syn_d    = s1_syn_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_syn_d   = out_syn_q;
        out_corr_d  = out_corr_q;
        out_unc_d   = out_unc_q;

        if (in_accept) begin
            s1_valid_d = 1'b1;
            s1_code_d  = in_code;
            s1_syn_d   = syn_comb;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end

        if (s2_load) begin
            out_valid_d = 1'b1;
            out_data_d  = fixed_data;
            out_syn_d   = s1_syn_q;
            out_corr_d  = corr_en;
            out_unc_d   = (s1_syn_q >= 5'd22);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Pipeline registers; reset discards every in-flight word.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_code_q   <= '0;
            s1_syn_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_syn_q   <= '0;
            out_corr_q  <= 1'b0;
            out_unc_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_code_q   <= s1_code_d;
            s1_syn_q    <= s1_syn_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_syn_q   <= out_syn_d;
            out_corr_q  <= out_corr_d;
            out_unc_q   <= out_unc_d;
        end
    end

    assign out_valid         = out_valid_q;
    assign out_data          = out_data_q;
    assign out_syndrome      = out_syn_q;
    assign out_corrected     = out_corr_q;
    assign out_uncorrectable = out_unc_q;

`ifdef HAMMING_ERR_CNT_EN
    logic [CNT_W-1:0] cnt_corr_q, cnt_corr_d;
    logic [CNT_W-1:0] cnt_unc_q, cnt_unc_d;

    // Saturating counters advance when a flagged word leaves stage 2; clear wins.
    always_comb begin
        cnt_corr_d = cnt_corr_q;
        cnt_unc_d  = cnt_unc_q;
        if (cnt_clear) begin
            cnt_corr_d = '0;
            cnt_unc_d  = '0;
        end else if (out_fire) begin
            if (out_corr_q && (cnt_corr_q != {CNT_W{1'b1}})) begin
                cnt_corr_d = cnt_corr_q + 1'b1;
            end
            if (out_unc_q && (cnt_unc_q != {CNT_W{1'b1}})) begin
                cnt_unc_d = cnt_unc_q + 1'b1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_corr_q <= '0;
            cnt_unc_q  <= '0;
        end else begin
            cnt_corr_q <= cnt_corr_d;
            cnt_unc_q  <= cnt_unc_d;
        end
    end

    assign cnt_corrected = cnt_corr_q;
    assign cnt_uncorr    = cnt_unc_q;
`endif

endmodule

// File: tb/tb_hamming_decoder_pipe.sv
// Scoreboard testbench for hamming_decoder_pipe: each accepted codeword pushes its
// expected decode result, and the output monitor pops and compares on every drain.
module tb_hamming_decoder_pipe;

    typedef struct packed {
        logic [15:0] d;
        logic [4:0]  s;
        logic        c;
        logic        u;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [20:0] in_code;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [4:0]  out_syndrome;
    logic        out_corrected;
    logic        out_uncorrectable;
`ifdef HAMMING_ERR_CNT_EN
    logic        cnt_clear;
    logic [1:0]  cnt_corrected;
    logic [1:0]  cnt_uncorr;
`endif

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_pops   = 0;
    bit   rand_rdy = 1'b0;
    bit   hold_v   = 1'b0;
    logic [22:0] hold_q;

    always #5 clk = ~clk;

    hamming_decoder_pipe #(.CNT_W(2)) dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_code           (in_code),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .out_syndrome      (out_syndrome),
        .out_corrected     (out_corrected),
        .out_uncorrectable (out_uncorrectable)
`ifdef HAMMING_ERR_CNT_EN
        ,
        .cnt_clear         (cnt_clear),
        .cnt_corrected     (cnt_corrected),
        .cnt_uncorr        (cnt_uncorr)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic bit is_pow2(input int p);
        return (p & (p - 1)) == 0;
    endfunction

    // Message index carried by position p, or -1 for a parity position.
    function automatic int data_idx(input int p);
        int j;
        if (is_pow2(p)) return -1;
        j = 0;
        for (int q = 1; q < p; q++) if (!is_pow2(q)) j++;
        return j;
    endfunction

    function automatic logic [20:0] enc(input logic [15:0] m);
        logic [20:0] c;
        logic        par;
        c = '0;
        for (int p = 1; p <= 21; p++) if (!is_pow2(p)) c[p-1] = m[data_idx(p)];
        for (int k = 0; k < 5; k++) begin
            par = 1'b0;
            for (int p = 1; p <= 21; p++) if (!is_pow2(p) && ((p >> k) & 1) == 1) par ^= c[p-1];
            c[(1 << k) - 1] = par;
        end
        return c;
    endfunction

    // Output monitor: ordered scoreboard compare plus hold-stability while stalled.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold_valid", {31'd0, out_valid}, 32'd1);
                chk("hold_fields", {9'd0, out_data, out_syndrome, out_corrected, out_uncorrectable},
                    {9'd0, hold_q});
            end
            hold_v = out_valid && !out_ready;
            hold_q = {out_data, out_syndrome, out_corrected, out_uncorrectable};
            if (out_valid && out_ready) begin
                n_pops++;
                if (sb.size() == 0) begin
                    chk("unexpected_out", {31'd0, out_valid}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    $display("out data=%h syn=%0d corr=%b unc=%b", out_data, out_syndrome,
                             out_corrected, out_uncorrectable);
                    chk("out_data", {16'd0, out_data}, {16'd0, e.d});
                    chk("out_syndrome", {27'd0, out_syndrome}, {27'd0, e.s});
                    chk("out_flags", {30'd0, out_corrected, out_uncorrectable}, {30'd0, e.c, e.u});
                end
            end
        end
    end

    task automatic send(input logic [20:0] code, input exp_t e);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        in_valid = 1'b1;
        in_code  = code;
        while (!acc && n < 200) begin
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = in_ready;
            if (acc) sb.push_back(e);
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) chk("send_timeout", {31'd0, acc}, 32'd1);
    endtask

    task automatic send_err(input logic [15:0] m, input int p);
        logic [20:0] c;
        exp_t e;
        c = enc(m);
        if (p != 0) c[p-1] = ~c[p-1];
        e.d = m;
        e.s = 5'(p);
        e.c = (p != 0);
        e.u = 1'b0;
        send(c, e);
    endtask

    task automatic send_dbl(input logic [15:0] m, input int a, input int b);
        logic [20:0] c;
        exp_t e;
        c = enc(m);
        c[a-1] = ~c[a-1];
        c[b-1] = ~c[b-1];
        e.d = m;
        if (data_idx(a) >= 0) e.d[data_idx(a)] = ~e.d[data_idx(a)];
        if (data_idx(b) >= 0) e.d[data_idx(b)] = ~e.d[data_idx(b)];
        e.s = 5'(a ^ b);
        e.c = 1'b0;
        e.u = 1'b1;
        send(c, e);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", sb.size(), 32'd0);
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sb.delete();
        rst = 1'b0;
    endtask

    logic [20:0] bp_code [4];
    exp_t        bp_exp  [4];

    initial begin
        int idx;
        int pops0;
        int n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_code   = '0;
        out_ready = 1'b1;
`ifdef HAMMING_ERR_CNT_EN
        cnt_clear = 1'b0;
`endif
        do_reset();

        // Reset state and first-cycle in_ready.
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_fields", {9'd0, out_data, out_syndrome, out_corrected, out_uncorrectable}, 32'd0);
        @(posedge clk);
        #1;

        // Clean all-ones word and two-cycle latency.
        send(21'h1FFFFE, '{d: 16'hFFFF, s: 5'd0, c: 1'b0, u: 1'b0});
        @(negedge clk);
        chk("lat_cycle1", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("lat_cycle2", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;

        // Fixed vectors: position-7 error in m=0, and a syndrome-30 double error.
        send(21'h000040, '{d: 16'h0000, s: 5'd7, c: 1'b1, u: 1'b0});
        send(21'h100400, '{d: 16'h8040, s: 5'd30, c: 1'b0, u: 1'b1});
        wait_drain();

        // Every single-bit error position on all-zero and all-one messages.
        for (int p = 1; p <= 21; p++) send_err(16'h0000, p);
        for (int p = 1; p <= 21; p++) send_err(16'hFFFF, p);
        wait_drain();

        // Backpressure: stall output, 2 words fill the pipe, then in_ready drops.
        for (int i = 0; i < 4; i++) begin
            bp_exp[i]  = '{d: 16'hA5A0 + 16'(i), s: 5'(i + 3), c: 1'b1, u: 1'b0};
            bp_code[i] = enc(bp_exp[i].d);
            bp_code[i][i+2] = ~bp_code[i][i+2];
        end
        out_ready = 1'b0;
        idx = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            in_valid = (idx < 4);
            in_code  = bp_code[idx < 4 ? idx : 3];
            @(negedge clk);
            if (in_valid && in_ready) begin
                sb.push_back(bp_exp[idx]);
                idx++;
            end
            @(posedge clk);
            #1;
        end
        chk("bp_accepted", idx, 32'd2);
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        pops0 = n_pops;
        for (int cyc = 0; cyc < 4; cyc++) begin
            in_valid = (idx < 4);
            in_code  = bp_code[idx < 4 ? idx : 3];
            @(negedge clk);
            if (in_valid && in_ready) begin
                sb.push_back(bp_exp[idx]);
                idx++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("bp_throughput", n_pops - pops0, 32'd4);
        wait_drain();

        // Random traffic with random output stalls.
        rand_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send_err(16'($urandom), (i % 3 == 0) ? 0 : $urandom_range(1, 21));
        end
        send_dbl(16'h1234, 20, 10);
        send_dbl(16'hBEEF, 21, 3);
        wait_drain();

        // Reset with two words in flight: nothing stale may appear afterwards.
        out_ready = 1'b0;
        send_err(16'h0F0F, 5);
        send_err(16'hF0F0, 9);
        rst = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        chk("midrst_quiet", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        send_err(16'h3C3C, 12);
        wait_drain();

`ifdef HAMMING_ERR_CNT_EN
        // Saturating counters with CNT_W=2, then clear colliding with an increment.
        do_reset();
        for (int i = 0; i < 5; i++) send_err(16'h1234, i + 3);
        wait_drain();
        @(negedge clk);
        chk("cnt_corr_sat", {30'd0, cnt_corrected}, 32'd3);
        chk("cnt_unc_zero", {30'd0, cnt_uncorr}, 32'd0);
        @(posedge clk);
        #1;
        send(21'h100400, '{d: 16'h8040, s: 5'd30, c: 1'b0, u: 1'b1});
        wait_drain();
        @(negedge clk);
        chk("cnt_unc_one", {30'd0, cnt_uncorr}, 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send_err(16'h5555, 6);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("cnt_wait_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        cnt_clear = 1'b1;
        @(posedge clk);
        #1;
        cnt_clear = 1'b0;
        @(negedge clk);
        chk("cnt_clear_prio", {30'd0, cnt_corrected}, 32'd0);
        chk("cnt_clear_unc", {30'd0, cnt_uncorr}, 32'd0);
        wait_drain();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hamming_decoder_pipe.md
Name: hamming_decoder_pipe

Overview:
- Downstream consumer of the 21-bit Hamming(21,16) encoder output.
- Accepts codewords over a valid/ready handshake and computes the 5-bit syndrome.
- Corrects any single-bit error and returns the 16-bit message through a 2-stage pipeline with full backpressure.
- Sits between the channel/storage model and the data sink.

Parameters:
- CNT_W, 16, width of the saturating error counters (used only when HAMMING_ERR_CNT_EN is defined).

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  codeword present on in_code
- in_ready  output  1  block can accept in_code this cycle
- in_code  input  21  codeword; bit i is Hamming position i+1
- out_valid  output  1  decoded word present
- out_ready  input  1  sink accepts the output this cycle
- out_data  output  16  corrected message
- out_syndrome  output  5  syndrome of the word on out_data
- out_corrected  output  1  single-bit error was corrected
- out_uncorrectable  output  1  syndrome in 22..31; no correction applied
- cnt_clear  input  1  (macro only) zero both counters
- cnt_corrected  output  CNT_W  (macro only) count of corrected words
- cnt_uncorr  output  CNT_W  (macro only) count of uncorrectable words

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-high.
- Code layout:
  - Parity bits sit at positions 1, 2, 4, 8, 16 (in_code[0], [1], [3], [7], [15]).
  - Data bits m[0..15] sit at positions 3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15, 17, 18, 19, 20, 21.
- Syndrome: bit k = XOR of all in_code positions whose index has bit k set (k = 0..4). It equals the XOR of the indices of all set positions.
- Stage 1 (S1): registers in_code and the computed syndrome. Handshake on in_valid && in_ready.
- Stage 2 (S2):
  - Syndrome 0: output data unchanged.
  - Syndrome 1..21: flip that position, then extract data; out_corrected=1. A flip on a parity position leaves data unchanged but still asserts out_corrected.
  - Syndrome 22..31: extract data uncorrected; out_uncorrectable=1.
  - Registers out_data, out_syndrome and both flags, and sets out_valid.
- Latency: 2 cycles from accepted input to out_valid when the output is unstalled. Throughput is 1 word/cycle.
- Flow control:
  - S2 loads when S1 is valid and (!out_valid || out_ready).
  - in_ready = !s1_valid || s1 advances this cycle. It is combinational from out_ready; there is no combinational path from in_valid.
  - Holding out_ready=0 fills both stages (2 words) then deasserts in_ready.
  - No word is dropped or duplicated, and order is preserved.
- Output stability: while out_valid && !out_ready, all out_* signals hold stable.
- Simultaneous accept and drain of both stages in the same cycle is allowed (full throughput).
- Reset values: out_valid=0, S1 valid=0, out_data=0, out_syndrome=0, out_corrected=0, out_uncorrectable=0, counters=0. in_ready reads 1 in the first cycle after reset.
- Reset mid-operation discards all in-flight words. Inputs are ignored on the reset cycle.
- Double-bit errors whose syndrome is 1..21 are miscorrected silently; the decoder provides SEC only.

Optional Feature:
- Macro: HAMMING_ERR_CNT_EN
- When defined:
  - cnt_clear, cnt_corrected and cnt_uncorr exist.
  - Each counter increments by 1 when a word with the matching flag leaves S2 (out_valid && out_ready).
  - Counters saturate at 2^CNT_W-1.
  - cnt_clear has priority over an increment in the same cycle.
  - Reset zeroes both counters.
- When undefined: these ports and registers are absent, and all other behaviour is identical.

Test Plan:
- Clean word: in_code=21'h1FFFFE (m=16'hFFFF) with out_ready=1 -> out_valid 2 cycles later, out_data=16'hFFFF, syndrome 0, both flags 0.
- Single data error: in_code=21'h000040 (position 7 flipped in m=0) -> out_data=16'h0000, syndrome 5'd7, out_corrected=1. Repeat for every position 1..21 on m=0 and m=FFFF: correct data every time.
- Uncorrectable: in_code=21'h100400 -> syndrome 5'd30, out_uncorrectable=1, out_corrected=0, out_data=16'h8040 (raw).
- Backpressure: send 4 words back-to-back with out_ready=0 for 6 cycles -> in_ready=0 after 2 accepted. Outputs held stable. After out_ready=1, all 4 words emerge in order at 1/cycle.
- Reset mid-stream: assert rst with 2 words in flight -> next cycle out_valid=0, in_ready=1, and no stale word ever appears.
- With HAMMING_ERR_CNT_EN and CNT_W=2: feed 5 corrected words -> cnt_corrected saturates at 3. Assert cnt_clear in the same cycle as a drained corrected word -> counter reads 0.
